axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter_if.sv | 26 ++
 rtl/axis_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle between the round-robin arbiter and its sources/consumer.
// The arbiter takes the slave view; the sources and the downstream reader take the master view.
interface axis_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4
);
  logic [NUM_SRC-1:0]            src_enable;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [2:0]                    m_axis_tid;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic [NUM_SRC-1:0]            grant;

  modport slave (
    input  src_enable, s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid, grant
  );

  modport master (
    output src_enable, s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid, grant
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NUM_SRC AXI-stream sources into one registered output,
// granting one source for up to BURST_LEN beats per arbitration.
module axis_rr_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  gnt,
  input  logic                  en,
  input  logic                  vld,
  input  logic                  can_load,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  req,
  output logic                  tready,
  output logic [DATA_WIDTH-1:0] data_m
);
  assign req    = vld & en;
  // a disabled granted source must not hand over a beat on its release cycle
  assign tready = gnt & en & can_load;
  assign data_m = gnt ? data : '0;
endmodule

module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int BURST_LEN  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  axis_rr_arbiter_if.slave  bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                              state;
  logic [NUM_SRC-1:0]                  grant_q;
  logic [IW-1:0]                       gidx;
  logic [IW-1:0]                       last_grant;
  logic [CW-1:0]                       beat_cnt;

  logic [NUM_SRC-1:0]                  req;
  logic [NUM_SRC-1:0]                  tready;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  data_m;
  logic [DATA_WIDTH-1:0]               sel_data;
  logic [IW-1:0]                       nxt_idx;
  logic [IW-1:0]                       cand;
  logic                                nxt_vld;

  logic                                m_valid_q;
  logic [DATA_WIDTH-1:0]               m_data_q;
  logic [2:0]                          m_tid_q;

  logic                                can_load;
  logic                                accept;
  logic                                last_beat;
  logic                                g_vld;
  logic                                g_en;

  assign can_load = ~m_valid_q | bus.m_axis_tready;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
      axis_rr_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .gnt      (grant_q[i]),
        .en       (bus.src_enable[i]),
        .vld      (bus.s_axis_tvalid[i]),
        .can_load (can_load),
        .data     (bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
        .req      (req[i]),
        .tready   (tready[i]),
        .data_m   (data_m[i])
      );
    end
  endgenerate

  // grant is one-hot, so an OR of the masked lanes is the data mux
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) sel_data = sel_data | data_m[i];
  end

  // scan from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    nxt_vld = 1'b0;
    nxt_idx = '0;
    cand    = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_SRC);
      if (req[cand]) begin
        nxt_vld = 1'b1;
        nxt_idx = cand;
      end
    end
  end

  assign accept    = |(tready & bus.s_axis_tvalid);
  assign last_beat = (beat_cnt == CW'(BURST_LEN - 1));
  assign g_vld     = bus.s_axis_tvalid[gidx];
  assign g_en      = bus.src_enable[gidx];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant_q    <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (nxt_vld) begin
            state         <= XFER;
            grant_q       <= '0;
            grant_q[nxt_idx] <= 1'b1;
            gidx          <= nxt_idx;
            last_grant    <= nxt_idx;
            beat_cnt      <= '0;
          end
        end
        XFER: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state   <= IDLE;
              grant_q <= '0;
            end
          end else if (!g_vld || !g_en) begin
            state   <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // output register: a held beat survives grant changes until the reader takes it
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_tid_q   <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= sel_data;
      m_tid_q   <= 3'(gidx);
    end else if (bus.m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.grant         = grant_q;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tid    = m_tid_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: source beats go into a scoreboard on
// acceptance and are compared in order as the merged stream delivers them.
module tb_axis_rr_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int BL = 4;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .BURST_LEN(BL)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  int             checks = 0;
  int             errors = 0;
  logic [DW+2:0]  sb[$];
  logic [2:0]     tid_log[$];
  bit             log_en = 1'b0;
  int             seq[NS];
  int             acc_cnt[NS];
  logic [NS-1:0]  acc_pend = '0;
  bit             prev_hold = 1'b0;
  logic [DW-1:0]  prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // each source emits {index, sequence number}
  always_comb
    for (int i = 0; i < NS; i++) bus.s_axis_tdata[i*DW +: DW] = {8'(i), 24'(seq[i])};

  // advance a source's data only after the edge that consumed it
  always @(posedge aclk)
    for (int i = 0; i < NS; i++) if (acc_pend[i]) seq[i] <= seq[i] + 1;

  always @(negedge aclk) begin
    acc_pend = '0;
    if (aresetn === 1'b1) begin
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.m_axis_tvalid), 64'(1));
        chk("hold_data", 64'(bus.m_axis_tdata), 64'(prev_data));
      end
      for (int i = 0; i < NS; i++)
        if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) begin
          sb.push_back({3'(i), bus.s_axis_tdata[i*DW +: DW]});
          acc_pend[i] = 1'b1;
          acc_cnt[i]++;
        end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else chk("beat", 64'({bus.m_axis_tid, bus.m_axis_tdata}), 64'(sb.pop_front()));
        if (log_en) tid_log.push_back(bus.m_axis_tid);
      end
      prev_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data = bus.m_axis_tdata;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic wait_grant(input string tag, input logic [NS-1:0] g, input int budget);
    int n;
    n = 0;
    @(negedge aclk);
    while (bus.grant !== g && n < budget) begin
      @(negedge aclk);
      n++;
    end
    chk(tag, 64'(bus.grant), 64'(g));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((sb.size() != 0 || bus.m_axis_tvalid) && n < 60);
    @(negedge aclk);
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int n;
    int start;
    aresetn = 1'b0;
    bus.src_enable    = '0;
    bus.s_axis_tvalid = '0;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_grant",  64'(bus.grant), 64'(0));
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    chk("rst_tdata",  64'(bus.m_axis_tdata), 64'(0));
    chk("rst_tid",    64'(bus.m_axis_tid), 64'(0));
    chk("rst_tready", 64'(bus.s_axis_tready), 64'(0));

    // all four sources busy: bursts of BL rotate 0,1,2,3
    @(posedge aclk); #1;
    aresetn = 1'b1;
    bus.src_enable    = '1;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 4'b1111;
    log_en = 1'b1;
    wait_grant("a_first", 4'b0001, 3);
    n = 0;
    while (tid_log.size() < 16 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("a_count", 64'(tid_log.size() >= 16), 64'(1));
    @(posedge aclk); #1 bus.s_axis_tvalid = '0;
    drain("a_drain");
    log_en = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("a_tid%0d", i), 64'(tid_log.size() > i ? tid_log[i] : 3'h7), 64'(i / 4));

    // single requester: BL beats, one idle cycle, same source again
    @(posedge aclk); #1 bus.s_axis_tvalid = 4'b0100;
    wait_grant("b_grant", 4'b0100, 5);
    n = 0;
    while (bus.grant === 4'b0100 && n < 20) begin
      n++;
      @(negedge aclk);
    end
    chk("b_len", 64'(n), 64'(BL));
    chk("b_gap", 64'(bus.grant), 64'(0));
    @(negedge aclk);
    chk("b_regrant", 64'(bus.grant), 64'(4'b0100));
    @(posedge aclk); #1 bus.s_axis_tvalid = '0;
    drain("b_drain");

    // reader back-pressure toggling during a burst
    @(posedge aclk); #1 bus.s_axis_tvalid = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      @(posedge aclk); #1 bus.m_axis_tready = i[0];
    end
    @(posedge aclk); #1;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = '0;
    drain("c_drain");

    // source 1 gives up after three beats; source 2 takes over
    @(posedge aclk); #1;
    start = acc_cnt[1];
    tid_log.delete();
    log_en = 1'b1;
    bus.s_axis_tvalid = 4'b0010;
    wait_grant("d_grant1", 4'b0010, 5);
    bus.s_axis_tvalid = 4'b0110;
    repeat (3) @(posedge aclk);
    #1 bus.s_axis_tvalid = 4'b0100;
    @(negedge aclk);
    @(negedge aclk);
    chk("d_release", 64'(bus.grant), 64'(0));
    chk("d_beats", 64'(acc_cnt[1] - start), 64'(3));
    @(negedge aclk);
    chk("d_next", 64'(bus.grant), 64'(4'b0100));
    @(posedge aclk); #1 bus.s_axis_tvalid = '0;
    drain("d_drain");
    log_en = 1'b0;
    chk("d_log_len", 64'(tid_log.size() >= 4), 64'(1));
    for (int i = 0; i < 3; i++)
      chk($sformatf("d_tid%0d", i), 64'(tid_log.size() > i ? tid_log[i] : 3'h7), 64'(1));
    chk("d_tid3", 64'(tid_log.size() > 3 ? tid_log[3] : 3'h7), 64'(2));

    // source 0 disabled while it holds the grant
    @(posedge aclk); #1;
    start = acc_cnt[0];
    bus.s_axis_tvalid = 4'b0011;
    wait_grant("e_grant0", 4'b0001, 5);
    @(posedge aclk); #1 bus.src_enable[0] = 1'b0;
    @(negedge aclk);
    chk("e_no_rdy", 64'(bus.s_axis_tready[0]), 64'(0));
    @(negedge aclk);
    chk("e_release", 64'(bus.grant), 64'(0));
    @(negedge aclk);
    chk("e_next", 64'(bus.grant), 64'(4'b0010));
    chk("e_beats0", 64'(acc_cnt[0] - start), 64'(1));
    @(posedge aclk); #1;
    bus.s_axis_tvalid = '0;
    bus.src_enable    = '1;
    drain("e_drain");

    // reset pulse with a beat stuck in the output register
    @(posedge aclk); #1;
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 4'b0100;
    wait_grant("f_grant", 4'b0100, 5);
    @(posedge aclk);
    @(posedge aclk); #1 aresetn = 1'b0;
    @(negedge aclk);
    chk("f_held", 64'(bus.m_axis_tvalid), 64'(1));
    @(posedge aclk); #1;
    aresetn = 1'b1;
    sb.delete();
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 4'b0101;
    @(negedge aclk);
    chk("f_grant0",  64'(bus.grant), 64'(0));
    chk("f_tvalid",  64'(bus.m_axis_tvalid), 64'(0));
    chk("f_tdata",   64'(bus.m_axis_tdata), 64'(0));
    chk("f_tid",     64'(bus.m_axis_tid), 64'(0));
    chk("f_tready",  64'(bus.s_axis_tready), 64'(0));
    wait_grant("f_first", 4'b0001, 3);
    @(posedge aclk); #1 bus.s_axis_tvalid = '0;
    drain("f_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
